// File: rtl/vga_dec_pkg.sv
// Shared 640x480@60 timing constants, decoder state type and a small helper.
package vga_dec_pkg;

   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned H_FP        = 16;
   localparam int unsigned H_SYNC      = 96;
   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned V_FP        = 10;
   localparam int unsigned V_SYNC      = 2;
   localparam int unsigned V_TOTAL     = 525;
   localparam bit          SYNC_POL    = 1'b0;
   localparam int unsigned LOCK_FRAMES = 2;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} dec_state_t;

   // 10-bit increment that sticks at 1023 instead of wrapping.
   function automatic logic [9:0] sat_inc(input logic [9:0] val, input logic inc);
      if (val == 10'h3FF) return val;
      return val + {9'd0, inc};
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Samples a sync line on each pixel strobe and flags the deasserted->asserted transition.
module sync_edge_det #(
   parameter bit SYNC_POL = 1'b0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic pixel_ce,
   input  logic sync_in,
   output logic assert_edge
);

   logic cur_asserted;
   logic prev_q;

   assign cur_asserted = (sync_in == SYNC_POL);

   // Previous sample, held while pixel_ce is low; reset value means "deasserted".
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         prev_q <= 1'b0;
      end else if (pixel_ce) begin
         prev_q <= cur_asserted;
      end
   end

   // Edge pulse is valid only during the strobe that sees it.
   assign assert_edge = pixel_ce & cur_asserted & ~prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: recovers coordinates, tracks lock and flags timing errors.
module vga_sync_decoder
   import vga_dec_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = vga_dec_pkg::H_ACTIVE,
   parameter int unsigned H_FP        = vga_dec_pkg::H_FP,
   parameter int unsigned H_TOTAL     = vga_dec_pkg::H_TOTAL,
   parameter int unsigned V_ACTIVE    = vga_dec_pkg::V_ACTIVE,
   parameter int unsigned V_FP        = vga_dec_pkg::V_FP,
   parameter int unsigned V_TOTAL     = vga_dec_pkg::V_TOTAL,
   parameter bit          SYNC_POL    = vga_dec_pkg::SYNC_POL,
   parameter int unsigned LOCK_FRAMES = vga_dec_pkg::LOCK_FRAMES
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       pixel_ce,
   input  logic       hs,
   input  logic       vs,
   input  logic       blank,
   input  logic       clr_err,
   output logic [9:0] RecX,
   output logic [9:0] RecY,
   output logic       rec_active,
   output logic       locked,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines,
   output logic [7:0] frame_cnt,
   output logic       err_hline,
   output logic       err_vframe,
   output logic       err_blank
);

   localparam logic [9:0] HA      = 10'(H_ACTIVE);
   localparam logic [9:0] VA      = 10'(V_ACTIVE);
   localparam logic [9:0] HT      = 10'(H_TOTAL);
   localparam logic [9:0] VT      = 10'(V_TOTAL);
   localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_EDGE  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] V_EDGE  = 10'(V_ACTIVE + V_FP);
   localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

   dec_state_t state_q, state_d;
   logic [9:0] h_q, h_d, v_q, v_d;
   logic [9:0] line_run_q, line_run_d, frame_run_q, frame_run_d;
   logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [9:0] line_meas, frame_meas;
   logic [7:0] good_q, good_d, frame_cnt_q, frame_cnt_d;
   logic       err_h_q, err_h_d, err_v_q, err_v_d, err_b_q, err_b_d;
   logic       rec_act_q, rec_act_d;
   logic       hs_edge, vs_edge, bad_line, bad_frame, in_active;

   sync_edge_det #(
      .SYNC_POL(SYNC_POL)
   ) u_hs_edge (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_ce   (pixel_ce),
      .sync_in    (hs),
      .assert_edge(hs_edge)
   );

   sync_edge_det #(
      .SYNC_POL(SYNC_POL)
   ) u_vs_edge (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_ce   (pixel_ce),
      .sync_in    (vs),
      .assert_edge(vs_edge)
   );

   // Coordinate counters: hs edge realigns the column, vs edge (applied last) realigns the row.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pixel_ce) begin
         if (hs_edge) begin
            h_d = H_EDGE;
         end else if (h_q == HT_LAST) begin
            h_d = '0;
            v_d = (v_q == VT_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
         if (vs_edge) v_d = V_EDGE;
      end
   end

   // Free-running line/frame length measurement, independent of lock state.
   always_comb begin
      line_run_d    = line_run_q;
      frame_run_d   = frame_run_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      // Strobes since last hs edge, counting this one; hs edges since last vs edge.
      line_meas     = sat_inc(line_run_q, 1'b1);
      frame_meas    = sat_inc(frame_run_q, hs_edge);
      if (pixel_ce) begin
         if (hs_edge) begin
            line_len_d = line_meas;
            line_run_d = '0;
         end else begin
            line_run_d = line_meas;
         end
         if (vs_edge) begin
            frame_lines_d = frame_meas;
            frame_run_d   = '0;
         end else begin
            frame_run_d = frame_meas;
         end
      end
   end

   assign bad_line  = hs_edge & (line_meas != HT);
   assign bad_frame = vs_edge & (frame_meas != VT);
   assign in_active = (h_d < HA) && (v_d < VA);

   // Lock FSM, frame counter and sticky errors; a new error beats a same-cycle clear.
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      frame_cnt_d = frame_cnt_q;
      err_h_d     = clr_err ? 1'b0 : err_h_q;
      err_v_d     = clr_err ? 1'b0 : err_v_q;
      err_b_d     = clr_err ? 1'b0 : err_b_q;
      unique case (state_q)
         SEARCH: begin
            if (vs_edge) begin
               state_d = VERIFY;
               good_d  = '0;
            end
         end
         VERIFY: begin
            if (bad_line || bad_frame) begin
               state_d = SEARCH;
            end else if (vs_edge) begin
               good_d = good_q + 8'd1;
               if (good_q + 8'd1 >= LOCK_N) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (bad_line) err_h_d = 1'b1;
            if (bad_frame) err_v_d = 1'b1;
            if (bad_line || bad_frame) begin
               state_d = SEARCH;
            end else if (vs_edge) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
            if (pixel_ce && (blank != in_active)) err_b_d = 1'b1;
         end
         default: state_d = SEARCH;
      endcase
      rec_act_d = (state_d == LOCKED) && in_active;
   end

   // State register for everything above.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= SEARCH;
         h_q           <= '0;
         v_q           <= '0;
         line_run_q    <= '0;
         frame_run_q   <= '0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         good_q        <= '0;
         frame_cnt_q   <= '0;
         err_h_q       <= 1'b0;
         err_v_q       <= 1'b0;
         err_b_q       <= 1'b0;
         rec_act_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         line_run_q    <= line_run_d;
         frame_run_q   <= frame_run_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         good_q        <= good_d;
         frame_cnt_q   <= frame_cnt_d;
         err_h_q       <= err_h_d;
         err_v_q       <= err_v_d;
         err_b_q       <= err_b_d;
         rec_act_q     <= rec_act_d;
      end
   end

   assign RecX        = h_q;
   assign RecY        = v_q;
   assign rec_active  = rec_act_q;
   assign locked      = (state_q == LOCKED);
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_hline   = err_h_q;
   assign err_vframe  = err_v_q;
   assign err_blank   = err_b_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken timing (26x14) so frames stay short.
module tb_vga_sync_decoder;

   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HSW = 4;
   localparam int HT  = 26;
   localparam int VA  = 8;
   localparam int VFP = 2;
   localparam int VSW = 2;
   localparam int VT  = 14;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       pixel_ce = 1'b0;
   logic       hs = 1'b1;
   logic       vs = 1'b1;
   logic       blank = 1'b0;
   logic       clr_err = 1'b0;
   logic [9:0] RecX, RecY, line_len, frame_lines;
   logic [7:0] frame_cnt;
   logic       rec_active, locked, err_hline, err_vframe, err_blank;

   int         n_assert = 0;
   int         n_fail = 0;
   int         gx = 0;
   int         gy = 0;
   logic       track = 1'b0;
   logic [20:0] exp_q[$];  // {rec_active, x, y}

   always #5 Clk = ~Clk;

   vga_sync_decoder #(
      .H_ACTIVE   (HA),
      .H_FP       (HFP),
      .H_TOTAL    (HT),
      .V_ACTIVE   (VA),
      .V_FP       (VFP),
      .V_TOTAL    (VT),
      .SYNC_POL   (1'b0),
      .LOCK_FRAMES(2)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_ce   (pixel_ce),
      .hs         (hs),
      .vs         (vs),
      .blank      (blank),
      .clr_err    (clr_err),
      .RecX       (RecX),
      .RecY       (RecY),
      .rec_active (rec_active),
      .locked     (locked),
      .line_len   (line_len),
      .frame_lines(frame_lines),
      .frame_cnt  (frame_cnt),
      .err_hline  (err_hline),
      .err_vframe (err_vframe),
      .err_blank  (err_blank)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".RecX"}, RecX, 0);
      chk({tag, ".RecY"}, RecY, 0);
      chk({tag, ".rec_active"}, rec_active, 0);
      chk({tag, ".locked"}, locked, 0);
      chk({tag, ".line_len"}, line_len, 0);
      chk({tag, ".frame_lines"}, frame_lines, 0);
      chk({tag, ".frame_cnt"}, frame_cnt, 0);
      chk({tag, ".err_hline"}, err_hline, 0);
      chk({tag, ".err_vframe"}, err_vframe, 0);
      chk({tag, ".err_blank"}, err_blank, 0);
   endtask

   // One pixel strobe followed by one idle Clk; scoreboard entry popped once the output is due.
   task automatic strobe(input logic hs_v, input logic vs_v, input logic bl, input logic clr,
                         input logic chk_en, input int ex, input int ey, input logic ea);
      logic [20:0] e;
      @(negedge Clk);
      hs = hs_v;
      vs = vs_v;
      blank = bl;
      clr_err = clr;
      pixel_ce = 1'b1;
      if (chk_en) exp_q.push_back({ea, 10'(ex), 10'(ey)});
      @(posedge Clk);
      #1;
      pixel_ce = 1'b0;
      clr_err = 1'b0;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("sb.RecX", RecX, e[19:10]);
         chk("sb.RecY", RecY, e[9:0]);
         chk("sb.rec_active", rec_active, e[20]);
      end
      @(posedge Clk);
      #1;
   endtask

   // Reference 26x14 generator, active-low syncs, vs toggling at column 0.
   task automatic pix(input logic force_b0, input logic clr);
      logic ha, va, act;
      ha  = (gx >= HA + HFP) && (gx < HA + HFP + HSW);
      va  = (gy >= VA + VFP) && (gy < VA + VFP + VSW);
      act = (gx < HA) && (gy < VA);
      strobe(~ha, ~va, act & ~force_b0, clr, track, gx, gy, act);
      gx++;
      if (gx == HT) begin
         gx = 0;
         gy++;
         if (gy == VT) gy = 0;
      end
   endtask

   task automatic run_until(input int x, input int y);
      int n = 0;
      while (!(gx == x && gy == y) && n < 2 * HT * VT) begin
         pix(1'b0, 1'b0);
         n++;
      end
      if (n >= 2 * HT * VT) begin
         n_assert++;
         n_fail++;
         $display("FAIL run_until: position (%0d,%0d) not reached", x, y);
      end
   endtask

   // Runs through the next vs assert edge (row VA+VFP, column 0) inclusive.
   task automatic next_vs();
      pix(1'b0, 1'b0);
      run_until(1, VA + VFP);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 Reset = 1'b1;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge Clk);
      Reset = 1'b0;

      // No syncs: free-running counters, no lock
      for (int i = 0; i < 30; i++) strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      chk("idle.RecX", RecX, 4);
      chk("idle.RecY", RecY, 1);
      chk("idle.locked", locked, 0);

      // hs and vs assert edges on the same strobe
      strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, HA + HFP, VA + VFP, 1'b0);
      chk("coincide.locked", locked, 0);

      // Fresh start for the ideal-timing sequence
      @(negedge Clk);
      Reset = 1'b1;
      #1 chk_all_zero("reset2");
      @(negedge Clk);
      Reset = 1'b0;
      gx = 0;
      gy = 0;

      // Ideal timing: lock on the 3rd vs edge
      next_vs();
      chk("vs1.locked", locked, 0);
      next_vs();
      chk("vs2.locked", locked, 0);
      chk("vs2.frame_lines", frame_lines, VT);
      chk("vs2.line_len", line_len, HT);
      next_vs();
      chk("vs3.locked", locked, 1);
      chk("vs3.frame_cnt", frame_cnt, 0);
      track = 1'b1;
      next_vs();
      track = 1'b0;
      chk("vs4.locked", locked, 1);
      chk("vs4.frame_cnt", frame_cnt, 1);
      chk("vs4.frame_lines", frame_lines, VT);
      chk("vs4.err_blank", err_blank, 0);
      repeat (5) @(posedge Clk);
      #1;
      chk("hold.RecX", RecX, 0);
      chk("hold.RecY", RecY, VA + VFP);
      chk("hold.frame_cnt", frame_cnt, 1);

      // Short line (front-porch column skipped) while locked
      run_until(HA, 3);
      gx = HA + 1;
      run_until(HA + HFP + 1, 3);
      chk("short.err_hline", err_hline, 1);
      chk("short.line_len", line_len, HT - 1);
      chk("short.locked", locked, 0);
      chk("short.err_blank", err_blank, 0);
      next_vs();
      chk("relock1.locked", locked, 0);
      next_vs();
      chk("relock2.locked", locked, 0);
      next_vs();
      chk("relock3.locked", locked, 1);
      chk("relock3.frame_cnt", frame_cnt, 1);
      chk("relock3.err_hline", err_hline, 1);

      // blank forced low inside the active area
      run_until(5, 5);
      pix(1'b1, 1'b0);
      chk("blank.err_blank", err_blank, 1);
      chk("blank.locked", locked, 1);
      run_until(0, 6);
      pix(1'b0, 1'b1);
      chk("clr.err_blank", err_blank, 0);
      chk("clr.err_hline", err_hline, 0);
      chk("clr.locked", locked, 1);

      // Frame one line short, clr_err on the same strobe as the vs edge
      run_until(0, VA);
      gy = VA + 1;
      run_until(0, VA + VFP);
      pix(1'b0, 1'b1);
      chk("shortf.err_vframe", err_vframe, 1);
      chk("shortf.frame_lines", frame_lines, VT - 1);
      chk("shortf.locked", locked, 0);
      chk("shortf.frame_cnt", frame_cnt, 1);

      // Relock, then asynchronous reset mid-frame
      next_vs();
      next_vs();
      chk("pre_rst2.locked", locked, 0);
      next_vs();
      chk("pre_rst3.locked", locked, 1);
      run_until(3, 5);
      @(negedge Clk);
      Reset = 1'b1;
      #1 chk_all_zero("midreset");
      @(negedge Clk);
      Reset = 1'b0;
      next_vs();
      chk("post_rst1.locked", locked, 0);
      next_vs();
      chk("post_rst2.locked", locked, 0);
      next_vs();
      chk("post_rst3.locked", locked, 1);
      chk("post_rst3.frame_cnt", frame_cnt, 0);
      chk("post_rst3.err_vframe", err_vframe, 0);
      chk("sb.empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
